// File: rtl/pipelined_hazard_datapath.sv
// Five-stage pipelined datapath (F/D/E/M/W) with operand forwarding, load-use and
// RAW stalling, branch/jump squashing, and a retired-instruction counter. Decode
// controls arrive from an external controller that looks at OP/funct3/funct7.
module pipelined_hazard_datapath #(
    parameter int unsigned INSTR_MEMORY_SIZE = 128,
    parameter int unsigned DATA_MEMORY_SIZE  = 128,
    parameter int unsigned FORWARDING_EN     = 1,
    parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        JumpD,
    input  logic        BranchD,
    input  logic        ALUSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic [1:0]  ImmSrcD,
    output logic [6:0]  OP,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        StallF,
    output logic        FlushE,
    output logic [31:0] RetireCount
);
    localparam int unsigned IW = (INSTR_MEMORY_SIZE > 1) ? $clog2(INSTR_MEMORY_SIZE) : 1;
    localparam int unsigned DW = (DATA_MEMORY_SIZE > 1) ? $clog2(DATA_MEMORY_SIZE) : 1;
    localparam bit fwd_on = (FORWARDING_EN != 0);

    typedef struct packed {
        logic        valid;
        logic [31:0] instr, pc, pcplus4;
    } d_t;
    typedef struct packed {
        logic        valid, reg_write, mem_write, jump, branch, alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctl;
        logic [31:0] rd1, rd2, pc, imm, pcplus4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;
    typedef struct packed {
        logic        valid, reg_write, mem_write;
        logic [1:0]  result_src;
        logic [31:0] alu_res, wdata, pcplus4;
        logic [4:0]  rd;
    } m_t;
    typedef struct packed {
        logic        valid, reg_write;
        logic [1:0]  result_src;
        logic [31:0] alu_res, rdata, pcplus4;
        logic [4:0]  rd;
    } w_t;

    logic [31:0] imem [INSTR_MEMORY_SIZE];
    logic [31:0] dmem [DATA_MEMORY_SIZE];
    logic [31:0] rf [32];

    logic [31:0]   pcf_q, pcf_d, instr_f, pcplus4_f, instr_d;
    logic [IW-1:0] imem_idx;
    logic [DW-1:0] dmem_idx;
    d_t d_q, d_d;
    e_t e_q, e_d;
    m_t m_q, m_d;
    w_t w_q, w_d;
    logic [4:0]  rs1_d, rs2_d;
    logic [31:0] rd1_d, rd2_d, imm_d;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] src_a, src_b, wdata_e, alu_res_e, pc_target_e, rdata_m, result_w, retire_q;
    logic        zero_e, pcsrc_e, lw_stall, raw_stall, stall, flush_e;

    function automatic logic writes_src(input logic v, input logic rw, input logic [4:0] rd,
                                        input logic [4:0] a, input logic [4:0] b);
        return v && rw && (rd != 5'd0) && (rd == a || rd == b);
    endfunction

    assign pcplus4_f = pcf_q + 32'd4;
    assign imem_idx  = IW'(32'(pcf_q[31:2]) % INSTR_MEMORY_SIZE);
    assign instr_f   = imem[imem_idx];

    assign instr_d = d_q.instr;
    assign rs1_d   = instr_d[19:15];
    assign rs2_d   = instr_d[24:20];
    assign OP      = instr_d[6:0];
    assign funct3  = instr_d[14:12];
    assign funct7  = instr_d[30];

    // Register file read; a write landing in W this cycle is bypassed straight to D.
    always_comb begin
        rd1_d = rf[rs1_d];
        rd2_d = rf[rs2_d];
        if (rs1_d == 5'd0) rd1_d = '0;
        else if (w_q.reg_write && w_q.rd == rs1_d) rd1_d = result_w;
        if (rs2_d == 5'd0) rd2_d = '0;
        else if (w_q.reg_write && w_q.rd == rs2_d) rd2_d = result_w;
    end

    // Immediate extension: I, S, B, J formats.
    always_comb begin
        imm_d = '0;
        case (ImmSrcD)
            2'b00:   imm_d = {{20{instr_d[31]}}, instr_d[31:20]};
            2'b01:   imm_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            2'b10:   imm_d = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
            default: imm_d = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21],
                              1'b0};
        endcase
    end

    // Hazard detection: load-use only when forwarding, any pending writer otherwise.
    always_comb begin
        lw_stall  = (e_q.result_src == 2'b01) && (e_q.rd != 5'd0) &&
                    (e_q.rd == rs1_d || e_q.rd == rs2_d);
        raw_stall = writes_src(e_q.valid, e_q.reg_write, e_q.rd, rs1_d, rs2_d) ||
                    writes_src(m_q.valid, m_q.reg_write, m_q.rd, rs1_d, rs2_d) ||
                    writes_src(w_q.valid, w_q.reg_write, w_q.rd, rs1_d, rs2_d);
        stall     = fwd_on ? lw_stall : raw_stall;
    end

    // A redirect squashes D, so any stall it would have caused is moot.
    assign flush_e = stall | pcsrc_e;
    assign StallF  = stall & ~pcsrc_e;
    assign FlushE  = flush_e;

    // Fetch and decode next state: redirect beats stall, stall holds.
    always_comb begin
        pcf_d = pcf_q;
        d_d   = d_q;
        if (pcsrc_e) begin
            pcf_d = pc_target_e;
            d_d   = '0;
        end else if (!stall) begin
            pcf_d       = pcplus4_f;
            d_d.valid   = 1'b1;
            d_d.instr   = instr_f;
            d_d.pc      = pcf_q;
            d_d.pcplus4 = pcplus4_f;
        end
    end

    // Execute next state: bubble on flush; controls gated so an empty D carries no effect.
    always_comb begin
        e_d = '0;
        if (!flush_e && d_q.valid) begin
            e_d.valid      = 1'b1;
            e_d.reg_write  = RegWriteD;
            e_d.mem_write  = MemWriteD;
            e_d.jump       = JumpD;
            e_d.branch     = BranchD;
            e_d.alu_src    = ALUSrcD;
            e_d.result_src = ResultSrcD;
            e_d.alu_ctl    = ALUControlD;
            e_d.rd1        = rd1_d;
            e_d.rd2        = rd2_d;
            e_d.pc         = d_q.pc;
            e_d.imm        = imm_d;
            e_d.pcplus4    = d_q.pcplus4;
            e_d.rs1        = rs1_d;
            e_d.rs2        = rs2_d;
            e_d.rd         = instr_d[11:7];
        end
    end

    // Operand forwarding, M before W; 10 = M, 01 = W, 00 = register value.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (fwd_on && m_q.reg_write && m_q.rd != 5'd0 && m_q.rd == e_q.rs1) fwd_a = 2'b10;
        else if (fwd_on && w_q.reg_write && w_q.rd != 5'd0 && w_q.rd == e_q.rs1) fwd_a = 2'b01;
        if (fwd_on && m_q.reg_write && m_q.rd != 5'd0 && m_q.rd == e_q.rs2) fwd_b = 2'b10;
        else if (fwd_on && w_q.reg_write && w_q.rd != 5'd0 && w_q.rd == e_q.rs2) fwd_b = 2'b01;
        src_a   = (fwd_a == 2'b10) ? m_q.alu_res : (fwd_a == 2'b01) ? result_w : e_q.rd1;
        wdata_e = (fwd_b == 2'b10) ? m_q.alu_res : (fwd_b == 2'b01) ? result_w : e_q.rd2;
        src_b   = e_q.alu_src ? e_q.imm : wdata_e;
    end

    // ALU and branch resolution.
    always_comb begin
        alu_res_e = '0;
        case (e_q.alu_ctl)
            3'b000:  alu_res_e = src_a + src_b;
            3'b001:  alu_res_e = src_a - src_b;
            3'b010:  alu_res_e = src_a & src_b;
            3'b011:  alu_res_e = src_a | src_b;
            3'b100:  alu_res_e = src_a ^ src_b;
            3'b101:  alu_res_e = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_res_e = '0;
        endcase
        zero_e      = (alu_res_e == 32'd0);
        pc_target_e = e_q.pc + e_q.imm;
        pcsrc_e     = e_q.jump | (e_q.branch & zero_e);
    end

    // Memory and writeback next state.
    always_comb begin
        m_d            = '0;
        m_d.valid      = e_q.valid;
        m_d.reg_write  = e_q.reg_write;
        m_d.mem_write  = e_q.mem_write;
        m_d.result_src = e_q.result_src;
        m_d.alu_res    = alu_res_e;
        m_d.wdata      = wdata_e;
        m_d.pcplus4    = e_q.pcplus4;
        m_d.rd         = e_q.rd;
        w_d            = '0;
        w_d.valid      = m_q.valid;
        w_d.reg_write  = m_q.reg_write;
        w_d.result_src = m_q.result_src;
        w_d.alu_res    = m_q.alu_res;
        w_d.rdata      = rdata_m;
        w_d.pcplus4    = m_q.pcplus4;
        w_d.rd         = m_q.rd;
    end

    assign dmem_idx = DW'(32'(m_q.alu_res[31:2]) % DATA_MEMORY_SIZE);
    assign rdata_m  = dmem[dmem_idx];
    assign result_w = (w_q.result_src == 2'b01) ? w_q.rdata :
                      (w_q.result_src == 2'b10) ? w_q.pcplus4 : w_q.alu_res;

    // Pipeline registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pcf_q <= RESET_PC;
            d_q   <= '0;
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
        end else begin
            pcf_q <= pcf_d;
            d_q   <= d_d;
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
        end
    end

    // Register file write; x0 is never written.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (w_q.reg_write && w_q.rd != 5'd0) begin
            rf[w_q.rd] <= result_w;
        end
    end

    // Data memory write; contents survive reset, but no store lands on a reset edge.
    always_ff @(posedge CLK) begin
        if (!RESET && m_q.mem_write) dmem[dmem_idx] <= m_q.wdata;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge CLK) begin
        if (RESET) retire_q <= '0;
        else if (w_q.valid) retire_q <= retire_q + 32'd1;
    end

    assign RetireCount = retire_q;
endmodule
